// File: rtl/load_store_unit.sv
// Load/store unit: one load or store per handshake onto a word-addressed, byte-enabled memory port; load data is extended for writeback.
// Latency: aligned access responds 2 cycles after accept, split access 3 cycles, rejected (faulting) request 1 cycle.
// Backpressure: req_ready is high only in IDLE; requests offered at other times are ignored and must be held by execute.
// Build option LSU_MISALIGNED_EN: when defined, accesses spanning two words are split into LO/HI word accesses;
// when undefined, every misaligned halfword/word access is rejected with rsp_fault.

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_word_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;

    // Request fields latched at accept
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              fault_q;
`ifdef LSU_MISALIGNED_EN
    logic              split_q;
    logic [31:0]       lo_word_q;
`endif

    // Decode of the incoming request
    logic              req_illegal;
    logic              req_fault;
`ifdef LSU_MISALIGNED_EN
    logic [2:0]        req_size;
    logic              req_split;
`else
    logic              req_misaligned;
`endif

    // Datapath helpers derived from the latched request
    logic [1:0]        off_q;
    logic [4:0]        off_bits;
    logic [3:0]        size_mask;
    logic [31:0]       ld_sh;
    logic [31:0]       ld_ext;

    assign off_q    = addr_q[1:0];
    assign off_bits = {off_q, 3'b000};

    // Classify the request on the input side: illegal width codes and (build-dependent) misalignment
    always_comb begin
        // 011 and 111 share funct3[1:0]=11; 110 is the remaining reserved load code
        req_illegal = (req_funct3[1:0] == 2'b11)
                   || (req_funct3[2] && req_funct3[1])
                   || (req_we && req_funct3[2]);
`ifdef LSU_MISALIGNED_EN
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_split = (({1'b0, req_addr[1:0]} + req_size) > 3'd4);
        req_fault = req_illegal;
`else
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                      || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_fault = req_illegal || req_misaligned;
`endif
    end

    // Sequencer: accept in IDLE, LO word access, optional HI word access, one-cycle DONE response
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
`ifdef LSU_MISALIGNED_EN
            split_q   <= 1'b0;
            lo_word_q <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        fault_q  <= req_fault;
`ifdef LSU_MISALIGNED_EN
                        split_q  <= req_split && !req_fault;
`endif
                        // A rejected request skips the memory entirely
                        state    <= req_fault ? S_DONE : S_LO;
                    end
                end
                S_LO: begin
`ifdef LSU_MISALIGNED_EN
                    state <= split_q ? S_HI : S_DONE;
`else
                    state <= S_DONE;
`endif
                end
`ifdef LSU_MISALIGNED_EN
                S_HI: begin
                    // Read data for the LO access arrives during HI
                    lo_word_q <= mem_rdata;
                    state     <= S_DONE;
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte mask for the access width before lane shifting
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Align load data: assemble the spanned bytes, shift to bit 0, then sign/zero extend
    always_comb begin
`ifdef LSU_MISALIGNED_EN
        if (split_q) begin
            ld_sh = 32'({mem_rdata, lo_word_q} >> off_bits);
        end else begin
            ld_sh = mem_rdata >> off_bits;
        end
`else
        ld_sh = mem_rdata >> off_bits;
`endif
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_ext = {24'h000000, ld_sh[7:0]};
            3'b101:  ld_ext = {16'h0000, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    // Port outputs are decoded from the registered state and latched request only (plus mem_rdata in DONE)
    always_comb begin
        req_ready     = (state == S_IDLE);
        rsp_valid     = 1'b0;
        rsp_fault     = 1'b0;
        rsp_rdata     = '0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_be        = '0;
        mem_word_addr = '0;
        mem_wdata     = '0;
        case (state)
            S_LO: begin
                mem_en        = 1'b1;
                mem_we        = we_q;
                // Shift results keep the 4/32-bit operand width, dropping lanes that belong to HI
                mem_be        = size_mask << off_q;
                mem_word_addr = addr_q[ADDR_W-1:2];
                mem_wdata     = wdata_q << off_bits;
            end
`ifdef LSU_MISALIGNED_EN
            S_HI: begin
                mem_en        = 1'b1;
                mem_we        = we_q;
                // Remaining lanes of the access; off is never 0 on a split
                mem_be        = size_mask >> (3'd4 - {1'b0, off_q});
                mem_word_addr = addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
                mem_wdata     = wdata_q >> (6'd32 - {1'b0, off_bits});
            end
`endif
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_fault = fault_q;
                if (!fault_q && !we_q) begin
                    rsp_rdata = ld_ext;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table plus back-to-back and reset-abort sequences.
// Works in both builds; expectations for misaligned accesses follow LSU_MISALIGNED_EN.
// A small byte-enabled memory with one-cycle read latency sits on the memory port.

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_word_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_word_addr(mem_word_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Memory: 16 words, byte-enabled writes, read data one cycle after the access
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) begin
                        mem[mem_word_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                    end
                end
            end else begin
                mem_rdata <= mem[mem_word_addr[3:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        int          nacc;
        logic [3:0]  be0;
        logic [29:0] wa0;
        logic [31:0] wd0;
        logic [3:0]  be1;
        logic [29:0] wa1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic fault, input logic [31:0] rdata,
                       input int lat, input int nacc, input logic [3:0] be0, input logic [29:0] wa0,
                       input logic [31:0] wd0, input logic [3:0] be1, input logic [29:0] wa1);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.fault = fault; v.rdata = rdata;
        v.lat = lat; v.nacc = nacc; v.be0 = be0; v.wa0 = wa0; v.wd0 = wd0; v.be1 = be1; v.wa1 = wa1;
        tbl.push_back(v);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    endtask

    // Issue one request at a negedge, then watch cycles 1..6 after the accept edge
    task automatic run_vec(input int idx, input vec_t v);
        int          lat = 0;
        int          nacc = 0;
        int          leak = 0;
        logic [3:0]  be0 = '0, be1 = '0;
        logic [29:0] wa0 = '0, wa1 = '0;
        logic [31:0] wd0 = '0, rd = '0;
        logic        we0 = 1'b0, flt = 1'b0;
        wait_ready();
        chk($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_en) begin
                if (nacc == 0) begin
                    be0 = mem_be; wa0 = mem_word_addr; wd0 = mem_wdata; we0 = mem_we;
                end else begin
                    be1 = mem_be; wa1 = mem_word_addr;
                end
                nacc++;
            end
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; flt = rsp_fault;
            end else if (rsp_rdata != 32'h0) begin
                leak++;
            end
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d fault", idx), {31'b0, flt}, {31'b0, v.fault});
        chk($sformatf("v%0d rdata", idx), rd, v.rdata);
        chk($sformatf("v%0d mem_accesses", idx), nacc, v.nacc);
        chk($sformatf("v%0d rdata_outside_done", idx), leak, 0);
        if (v.nacc >= 1) begin
            chk($sformatf("v%0d lo_be", idx), {28'b0, be0}, {28'b0, v.be0});
            chk($sformatf("v%0d lo_addr", idx), {2'b0, wa0}, {2'b0, v.wa0});
            chk($sformatf("v%0d lo_wdata", idx), wd0, v.wd0);
            chk($sformatf("v%0d lo_we", idx), {31'b0, we0}, {31'b0, v.we});
        end
        if (v.nacc >= 2) begin
            chk($sformatf("v%0d hi_be", idx), {28'b0, be1}, {28'b0, v.be1});
            chk($sformatf("v%0d hi_addr", idx), {2'b0, wa1}, {2'b0, v.wa1});
        end
    endtask

    initial begin
        logic [4:0] en_v, rv_v, rdy_v;
        logic [31:0] b2b_rd;
        int          rv_seen;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        mem[0] <= 32'h44332211;
        mem[1] <= 32'h88776655;
        mem[3] <= 32'h80FF7F01;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst rsp_fault", {31'b0, rsp_fault}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst mem_word_addr", {2'b0, mem_word_addr}, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        //   we  f3      addr    wdata         flt rdata         lat nacc be0      wa0 wd0           be1      wa1
        add(1, 3'b010, 32'h08, 32'hDEADBEEF, 0, 32'h0,        2, 1, 4'b1111, 2, 32'hDEADBEEF, 4'b0000, 0);
        add(0, 3'b010, 32'h08, 32'h0,        0, 32'hDEADBEEF, 2, 1, 4'b1111, 2, 32'h0,        4'b0000, 0);
        add(0, 3'b000, 32'h0D, 32'h0,        0, 32'h0000007F, 2, 1, 4'b0010, 3, 32'h0,        4'b0000, 0);
        add(0, 3'b000, 32'h0F, 32'h0,        0, 32'hFFFFFF80, 2, 1, 4'b1000, 3, 32'h0,        4'b0000, 0);
        add(0, 3'b100, 32'h0F, 32'h0,        0, 32'h00000080, 2, 1, 4'b1000, 3, 32'h0,        4'b0000, 0);
        add(0, 3'b101, 32'h0E, 32'h0,        0, 32'h000080FF, 2, 1, 4'b1100, 3, 32'h0,        4'b0000, 0);
        add(0, 3'b001, 32'h0E, 32'h0,        0, 32'hFFFF80FF, 2, 1, 4'b1100, 3, 32'h0,        4'b0000, 0);
`ifdef LSU_MISALIGNED_EN
        add(0, 3'b010, 32'h03, 32'h0,        0, 32'h77665544, 3, 2, 4'b1000, 0, 32'h0,        4'b0111, 1);
        add(0, 3'b001, 32'h01, 32'h0,        0, 32'h00003322, 2, 1, 4'b0110, 0, 32'h0,        4'b0000, 0);
`else
        add(0, 3'b010, 32'h03, 32'h0,        1, 32'h0,        1, 0, 4'b0000, 0, 32'h0,        4'b0000, 0);
        add(0, 3'b001, 32'h01, 32'h0,        1, 32'h0,        1, 0, 4'b0000, 0, 32'h0,        4'b0000, 0);
`endif
        add(1, 3'b000, 32'h06, 32'h000000AB, 0, 32'h0,        2, 1, 4'b0100, 1, 32'h00AB0000, 4'b0000, 0);
        add(1, 3'b001, 32'h12, 32'h00001234, 0, 32'h0,        2, 1, 4'b1100, 4, 32'h12340000, 4'b0000, 0);
        add(0, 3'b001, 32'h12, 32'h0,        0, 32'h00001234, 2, 1, 4'b1100, 4, 32'h0,        4'b0000, 0);
        add(1, 3'b000, 32'h10, 32'hFFFFFF5A, 0, 32'h0,        2, 1, 4'b0001, 4, 32'hFFFFFF5A, 4'b0000, 0);
        add(0, 3'b100, 32'h10, 32'h0,        0, 32'h0000005A, 2, 1, 4'b0001, 4, 32'h0,        4'b0000, 0);
        add(0, 3'b010, 32'h10, 32'h0,        0, 32'h1234005A, 2, 1, 4'b1111, 4, 32'h0,        4'b0000, 0);
        add(0, 3'b011, 32'h00, 32'h0,        1, 32'h0,        1, 0, 4'b0000, 0, 32'h0,        4'b0000, 0);
        add(1, 3'b100, 32'h00, 32'h00000055, 1, 32'h0,        1, 0, 4'b0000, 0, 32'h0,        4'b0000, 0);
        add(0, 3'b110, 32'h04, 32'h0,        1, 32'h0,        1, 0, 4'b0000, 0, 32'h0,        4'b0000, 0);
        add(0, 3'b111, 32'h04, 32'h0,        1, 32'h0,        1, 0, 4'b0000, 0, 32'h0,        4'b0000, 0);

        for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

        // SB must have touched only byte 2 of word 1
        @(negedge clk);
        chk("mem word1 after SB", mem[1], 32'h88AB6655);

        // Back-to-back: req_valid held high across two LW 0x8; no accept during DONE
        wait_ready();
        en_v = '0; rv_v = '0; rdy_v = '0; b2b_rd = '0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h08; req_wdata = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            en_v[c-1]  = mem_en;
            rv_v[c-1]  = rsp_valid;
            rdy_v[c-1] = req_ready;
            if (c == 5) b2b_rd = rsp_rdata;
        end
        req_valid = 1'b0;
        chk("b2b mem_en pattern", {27'b0, en_v}, {27'b0, 5'b01001});
        chk("b2b rsp_valid pattern", {27'b0, rv_v}, {27'b0, 5'b10010});
        chk("b2b req_ready pattern", {27'b0, rdy_v}, {27'b0, 5'b00100});
        chk("b2b second rdata", b2b_rd, 32'hDEADBEEF);

        // Reset while a store is in flight: no response, first word stays written
        @(negedge clk);
        wait_ready();
        rv_seen = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
`ifdef LSU_MISALIGNED_EN
        req_addr = 32'h22; req_wdata = 32'hCAFEF00D;
`else
        req_addr = 32'h20; req_wdata = 32'h12345678;
`endif
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort lo mem_en", {31'b0, mem_en}, 32'd1);
`ifdef LSU_MISALIGNED_EN
        chk("abort lo mem_be", {28'b0, mem_be}, {28'b0, 4'b1100});
        @(negedge clk);
        chk("abort hi mem_be", {28'b0, mem_be}, {28'b0, 4'b0011});
        chk("abort hi addr", {2'b0, mem_word_addr}, 32'd9);
`endif
        if (rsp_valid) rv_seen++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort req_ready", {31'b0, req_ready}, 32'd1);
        chk("abort mem_en", {31'b0, mem_en}, 32'd0);
        if (rsp_valid) rv_seen++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) rv_seen++;
        end
        chk("abort rsp_valid never", rv_seen, 0);
`ifdef LSU_MISALIGNED_EN
        chk("abort lo word written", mem[8], 32'hF00D0000);
`else
        chk("abort word written", mem[8], 32'h12345678);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and the data memory. Accepts one load or store per handshake, drives a word-addressed, byte-enabled memory port, and returns sign- or zero-extended load data to writeback. Misaligned accesses can optionally be split into two word accesses.

## Interface
- ADDR_W, 32, byte-address width; the memory word address is ADDR_W-2 bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  qualifies rsp_valid; the access was rejected.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables; bit i selects byte i.
- mem_word_addr  out  ADDR_W-2  word index.
- mem_wdata  out  32  byte-lane-shifted store data.
- mem_rdata  in  32  read data, valid the cycle after mem_en=1 with mem_we=0.

## Operation
States:
- IDLE
  - req_ready=1.
  - req_valid=1 accepts the request: latch we, funct3, addr, wdata.
  - Illegal funct3 (011, 110, 111, or a store with funct3[2]=1) or disallowed misalignment: set the fault flag and go to DONE.
  - Otherwise go to LO.
- LO
  - mem_en=1, mem_word_addr=addr[ADDR_W-1:2].
  - mem_be = size mask (0001 / 0011 / 1111) << off, truncated to 4 bits, where off = addr[1:0].
  - mem_wdata = wdata << 8*off.
  - If off + size > 4 (split), go to HI; otherwise go to DONE.
- HI
  - mem_en=1, mem_word_addr = LO word + 1, wrapping mod 2^(ADDR_W-2).
  - mem_be = mask >> (4-off); mem_wdata = wdata >> 8*(4-off).
  - Capture mem_rdata (LO read data) into a low-word register.
  - Go to DONE.
- DONE
  - rsp_valid=1, rsp_fault = fault flag. Go to IDLE.
  - Loads: form the 64-bit value {mem_rdata, low-word}, or {0, mem_rdata} when not split. Shift it right by 8*off, keep 1, 2 or 4 bytes, then extend:
    - LB/LH sign-extend.
    - LBU/LHU zero-extend.
- Outside LO and HI: mem_en=0, mem_we=0, mem_be=0.
- mem_we = latched we during LO and HI.
- A fault never asserts mem_en.
- rst in any state: next state IDLE, all latches cleared.
  - Any half-completed split store is not rolled back; its first word stays written.

## Timing
Reset values (cycle after rst): req_ready=1; rsp_valid=0; rsp_fault=0; rsp_rdata=0; mem_en=0; mem_we=0; mem_be=0; mem_word_addr=0; mem_wdata=0.

Latency, counted from the accept edge (cycle 0):
- Aligned access: LO in cycle 1, rsp_valid in cycle 2.
- Split access: LO in cycle 1, HI in cycle 2, rsp_valid in cycle 3.
- Fault: rsp_valid in cycle 1.

Handshake and data rules:
- No accept in DONE. Back-to-back aligned throughput is one request per 3 cycles.
- Requests presented while req_ready=0 are ignored. Execute must hold req_valid and its data until it sees req_ready.
- rsp_rdata depends combinationally on mem_rdata in DONE only. Outside DONE it is 0.

## Configuration
- LSU_MISALIGNED_EN defined: misaligned accesses whose bytes span two words are split via HI.
- LSU_MISALIGNED_EN undefined: any misaligned access faults. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - HI is unreachable and may be omitted.
  - Accesses that fit within one word but are misaligned still fault.

## Test plan
- SW addr 0x8, wdata 0xDEADBEEF, then LW addr 0x8:
  - store: mem_be=1111, mem_word_addr=2 in cycle 1.
  - load: rsp_rdata=0xDEADBEEF in cycle 2.
- Word 3 = 0x80FF7F01:
  - LB addr 0xD → 0x0000007F.
  - LB addr 0xF → 0xFFFFFF80.
  - LBU addr 0xF → 0x00000080.
  - LHU addr 0xE → 0x000080FF.
- SB addr 0x6, wdata 0x000000AB → mem_be=0100, mem_wdata=0x00AB0000, mem_word_addr=1.
- With LSU_MISALIGNED_EN, word 0 = 0x44332211, word 1 = 0x88776655:
  - LW addr 0x3 → LO be=1000, HI be=0111, word addrs 0 then 1, rsp_rdata=0x77665544 in cycle 3.
  - Without the macro, the same request → rsp_fault=1 in cycle 1, mem_en never high.
- funct3=011 load, and SB with funct3=100 → rsp_fault=1, rsp_rdata=0, no memory access.
- rst asserted during HI of a split SW → next cycle IDLE, req_ready=1, mem_en=0, rsp_valid never pulses; the LO word remains written.
